// File: rtl/ldm_stm_seq.sv
// Block load/store sequencer: walks a register list, issues one word access per
// listed register, and optionally writes the updated base back to Rn.
module ldm_stm_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_load,
    input  logic        up,
    input  logic        pre,
    input  logic        wback,
    input  logic [3:0]  rn,
    input  logic [31:0] base,
    input  logic [15:0] reglist,
    output logic [3:0]  ra,
    input  logic [31:0] rd,
    output logic [3:0]  wa3,
    output logic [31:0] wd3,
    output logic        we3,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_XFER  = 3'd2,
        S_WB    = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        load_q, load_d;
    logic        up_q, up_d;
    logic        pre_q, pre_d;
    logic        wback_q, wback_d;
    logic        rn_hit_q, rn_hit_d;
    logic [3:0]  rn_q, rn_d;
    logic [31:0] base_q, base_d;
    logic [15:0] list_q, list_d;
    logic [31:0] final_q, final_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  ra_q, ra_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [3:0]  cur;
    logic        ack_ok;
    logic [4:0]  n_regs;
    logic [31:0] span;

    function automatic logic [4:0] popcount16(input logic [15:0] l);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, l[i]};
        end
        return c;
    endfunction

    function automatic logic [3:0] lowest16(input logic [15:0] l);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (l[i]) r = 4'(i);
        end
        return r;
    endfunction

    assign cur    = lowest16(list_q);
    assign ack_ok = (state_q == S_XFER) && mem_req_q && mem_ack;
    assign n_regs = popcount16(list_q);
    assign span   = {25'd0, n_regs, 2'b00};

    always_comb begin
        state_d    = state_q;
        load_d     = load_q;
        up_d       = up_q;
        pre_d      = pre_q;
        wback_d    = wback_q;
        rn_hit_d   = rn_hit_q;
        rn_d       = rn_q;
        base_d     = base_q;
        list_d     = list_q;
        final_d    = final_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        ra_d       = ra_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_d   = is_load;
                    up_d     = up;
                    pre_d    = pre;
                    wback_d  = wback;
                    rn_d     = rn;
                    rn_hit_d = reglist[rn];
                    base_d   = base;
                    list_d   = reglist;
                    busy_d   = 1'b1;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                final_d = up_q ? base_q + span : base_q - span;
                if (n_regs == 5'd0) begin
                    state_d = S_WB;
                end else begin
                    state_d   = S_XFER;
                    mem_req_d = 1'b1;
                    mem_we_d  = ~load_q;
                    ra_d      = cur;
                    // Lowest register always sits at the lowest address.
                    case ({up_q, pre_q})
                        2'b10:   mem_addr_d = base_q;
                        2'b11:   mem_addr_d = base_q + 32'd4;
                        2'b00:   mem_addr_d = base_q - span + 32'd4;
                        default: mem_addr_d = base_q - span;
                    endcase
                end
            end
            S_XFER: begin
                if (ack_ok) begin
                    list_d = list_q & ~(16'd1 << cur);
                    if (list_d == 16'd0) begin
                        state_d    = S_WB;
                        mem_req_d  = 1'b0;
                        mem_we_d   = 1'b0;
                        mem_addr_d = 32'd0;
                        ra_d       = 4'd0;
                    end else begin
                        mem_addr_d = mem_addr_q + 32'd4;
                        ra_d       = lowest16(list_d);
                    end
                end
            end
            S_WB: begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            load_q     <= 1'b0;
            up_q       <= 1'b0;
            pre_q      <= 1'b0;
            wback_q    <= 1'b0;
            rn_hit_q   <= 1'b0;
            rn_q       <= 4'd0;
            base_q     <= 32'd0;
            list_q     <= 16'd0;
            final_q    <= 32'd0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 32'd0;
            ra_q       <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_q     <= load_d;
            up_q       <= up_d;
            pre_q      <= pre_d;
            wback_q    <= wback_d;
            rn_hit_q   <= rn_hit_d;
            rn_q       <= rn_d;
            base_q     <= base_d;
            list_q     <= list_d;
            final_q    <= final_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            ra_q       <= ra_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Load writes land in the ack cycle itself, so the write port is decoded from state.
    always_comb begin
        we3 = 1'b0;
        wa3 = 4'd0;
        wd3 = 32'd0;
        if (ack_ok && load_q) begin
            we3 = 1'b1;
            wa3 = cur;
            wd3 = mem_rdata;
        end else if (state_q == S_WB && wback_q && !(load_q && rn_hit_q)) begin
            we3 = 1'b1;
            wa3 = rn_q;
            wd3 = final_q;
        end
    end

    assign mem_wdata = (state_q == S_XFER && mem_we_q) ? rd : 32'd0;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign ra        = ra_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
